tex_lsu_cache_arb: RTL

Two-requester arbiter sharing one core data-cache port between the LSU and the texture unit inside the execute stage. Arbitrates requests round-robin and registers the winner onto the cache request channel. Inserts a source-select bit into the tag, then uses it to route each cache response back to its owner through a registered response stage. Full throughput, one cycle latency on each direction.

---
 rtl/tex_lsu_cache_arb.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/tex_lsu_cache_arb.sv
// Shares one data-cache port between the LSU and the texture unit: round-robin
// request arbitration with a registered request stage, tag-routed registered response stage.
module tex_lsu_cache_arb #(
    parameter int NUM_LANES     = 4,
    parameter int WORD_SIZE     = 4,
    parameter int ADDR_WIDTH    = 30,
    parameter int TAG_IN_WIDTH  = 8,
    parameter int TAG_SEL_IDX   = 0,
    localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + 1,
    localparam int BE_W          = NUM_LANES * WORD_SIZE,
    localparam int AD_W          = NUM_LANES * ADDR_WIDTH,
    localparam int DT_W          = NUM_LANES * WORD_SIZE * 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_LANES-1:0]     lsu_req_valid,
    input  logic                     lsu_req_rw,
    input  logic [BE_W-1:0]          lsu_req_byteen,
    input  logic [AD_W-1:0]          lsu_req_addr,
    input  logic [DT_W-1:0]          lsu_req_data,
    input  logic [TAG_IN_WIDTH-1:0]  lsu_req_tag,
    output logic                     lsu_req_ready,
    input  logic [NUM_LANES-1:0]     tex_req_valid,
    input  logic                     tex_req_rw,
    input  logic [BE_W-1:0]          tex_req_byteen,
    input  logic [AD_W-1:0]          tex_req_addr,
    input  logic [DT_W-1:0]          tex_req_data,
    input  logic [TAG_IN_WIDTH-1:0]  tex_req_tag,
    output logic                     tex_req_ready,
    output logic [NUM_LANES-1:0]     cache_req_valid,
    output logic                     cache_req_rw,
    output logic [BE_W-1:0]          cache_req_byteen,
    output logic [AD_W-1:0]          cache_req_addr,
    output logic [DT_W-1:0]          cache_req_data,
    output logic [TAG_OUT_WIDTH-1:0] cache_req_tag,
    input  logic                     cache_req_ready,
    input  logic                     cache_rsp_valid,
    input  logic [NUM_LANES-1:0]     cache_rsp_tmask,
    input  logic [DT_W-1:0]          cache_rsp_data,
    input  logic [TAG_OUT_WIDTH-1:0] cache_rsp_tag,
    output logic                     cache_rsp_ready,
    output logic                     lsu_rsp_valid,
    output logic [NUM_LANES-1:0]     lsu_rsp_tmask,
    output logic [DT_W-1:0]          lsu_rsp_data,
    output logic [TAG_IN_WIDTH-1:0]  lsu_rsp_tag,
    input  logic                     lsu_rsp_ready,
    output logic                     tex_rsp_valid,
    output logic [NUM_LANES-1:0]     tex_rsp_tmask,
    output logic [DT_W-1:0]          tex_rsp_data,
    output logic [TAG_IN_WIDTH-1:0]  tex_rsp_tag,
    input  logic                     tex_rsp_ready
);

    logic                     prio_reg;
    logic [NUM_LANES-1:0]     req_valid_reg;
    logic                     req_rw_reg;
    logic [BE_W-1:0]          req_byteen_reg;
    logic [AD_W-1:0]          req_addr_reg;
    logic [DT_W-1:0]          req_data_reg;
    logic [TAG_OUT_WIDTH-1:0] req_tag_reg;

    logic                     rsp_valid_reg;
    logic                     rsp_owner_reg;
    logic [NUM_LANES-1:0]     rsp_tmask_reg;
    logic [DT_W-1:0]          rsp_data_reg;
    logic [TAG_IN_WIDTH-1:0]  rsp_tag_reg;

    logic lsu_req, tex_req, any_req, win_tex, ld, rl, owner_ready, rsp_sel;
    logic [TAG_IN_WIDTH-1:0]  win_tag;
    logic [TAG_OUT_WIDTH-1:0] win_tag_ins;
    logic [TAG_IN_WIDTH-1:0]  rsp_tag_strip;

    assign lsu_req = |lsu_req_valid;
    assign tex_req = |tex_req_valid;
    assign any_req = lsu_req | tex_req;
    // TEX wins when alone or when both request and the pointer favours it
    assign win_tex = tex_req & (~lsu_req | prio_reg);
    assign ld      = ~(|req_valid_reg) | cache_req_ready;

    assign lsu_req_ready = ld & lsu_req & ~win_tex;
    assign tex_req_ready = ld & win_tex;
    assign win_tag       = win_tex ? tex_req_tag : lsu_req_tag;

    genvar gi;
    generate
        for (gi = 0; gi < TAG_OUT_WIDTH; gi++) begin : g_tag_ins
            if (gi < TAG_SEL_IDX) begin : g_lo
                assign win_tag_ins[gi] = win_tag[gi];
            end else if (gi == TAG_SEL_IDX) begin : g_sel
                assign win_tag_ins[gi] = win_tex;
            end else begin : g_hi
                assign win_tag_ins[gi] = win_tag[gi-1];
            end
        end
        for (gi = 0; gi < TAG_IN_WIDTH; gi++) begin : g_tag_strip
            if (gi < TAG_SEL_IDX) begin : g_lo
                assign rsp_tag_strip[gi] = cache_rsp_tag[gi];
            end else begin : g_hi
                assign rsp_tag_strip[gi] = cache_rsp_tag[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_reg       <= 1'b0;
            req_valid_reg  <= '0;
            req_rw_reg     <= 1'b0;
            req_byteen_reg <= '0;
            req_addr_reg   <= '0;
            req_data_reg   <= '0;
            req_tag_reg    <= '0;
        end else if (ld) begin
            req_valid_reg <= win_tex ? tex_req_valid : lsu_req_valid;
            if (any_req) begin
                prio_reg       <= ~win_tex;
                req_rw_reg     <= win_tex ? tex_req_rw     : lsu_req_rw;
                req_byteen_reg <= win_tex ? tex_req_byteen : lsu_req_byteen;
                req_addr_reg   <= win_tex ? tex_req_addr   : lsu_req_addr;
                req_data_reg   <= win_tex ? tex_req_data   : lsu_req_data;
                req_tag_reg    <= win_tag_ins;
            end
        end
    end

    assign cache_req_valid  = req_valid_reg;
    assign cache_req_rw     = req_rw_reg;
    assign cache_req_byteen = req_byteen_reg;
    assign cache_req_addr   = req_addr_reg;
    assign cache_req_data   = req_data_reg;
    assign cache_req_tag    = req_tag_reg;

    // Response side: a stalled owner blocks the buffer, and hence the cache
    assign rsp_sel         = cache_rsp_tag[TAG_SEL_IDX];
    assign owner_ready     = rsp_owner_reg ? tex_rsp_ready : lsu_rsp_ready;
    assign rl              = ~rsp_valid_reg | owner_ready;
    assign cache_rsp_ready = rl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_reg <= 1'b0;
            rsp_owner_reg <= 1'b0;
            rsp_tmask_reg <= '0;
            rsp_data_reg  <= '0;
            rsp_tag_reg   <= '0;
        end else if (rl) begin
            rsp_valid_reg <= cache_rsp_valid;
            if (cache_rsp_valid) begin
                rsp_owner_reg <= rsp_sel;
                rsp_tmask_reg <= cache_rsp_tmask;
                rsp_data_reg  <= cache_rsp_data;
                rsp_tag_reg   <= rsp_tag_strip;
            end
        end
    end

    assign lsu_rsp_valid = rsp_valid_reg & ~rsp_owner_reg;
    assign tex_rsp_valid = rsp_valid_reg & rsp_owner_reg;
    assign lsu_rsp_tmask = rsp_tmask_reg;
    assign tex_rsp_tmask = rsp_tmask_reg;
    assign lsu_rsp_data  = rsp_data_reg;
    assign tex_rsp_data  = rsp_data_reg;
    assign lsu_rsp_tag   = rsp_tag_reg;
    assign tex_rsp_tag   = rsp_tag_reg;

endmodule
